fb_display_arbiter: RTL and testbench



---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_display_arbiter_if.sv | 57 +++++
 rtl/fb_addr_gen.sv | 33 +++
 rtl/fb_display_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fb_display_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Purpose : shared constants, FSM state type and helpers for the frame-buffer
//           display arbiter (320x240 4-bit grayscale image, 2x upscaled to
//           a 640x480 scan-out).
// Contents:
//   IMG_W, IMG_H   image geometry in pixels
//   ADDR_W, PIX_W  BRAM address / pixel widths
//   IMG_PIXELS     number of stored pixels (first out-of-image address)
//   fb_state_t     arbiter FSM states (FILL=0, ARMED=1, SHOW=2)
//   in_image()     true when a BRAM address lies inside the image
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 4;

  localparam logic [ADDR_W-1:0] IMG_PIXELS = ADDR_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    FILL  = 2'd0,  // display idle, output forced black
    ARMED = 2'd1,  // a completed frame exists, waiting for a frame boundary
    SHOW  = 2'd2   // scan-out active, terminal until reset
  } fb_state_t;

  // Writer addresses at or beyond the image end are accepted but never
  // reach the BRAM port.
  function automatic logic in_image(input logic [ADDR_W-1:0] addr);
    return (addr < IMG_PIXELS);
  endfunction

endpackage

// File: rtl/fb_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_display_arbiter_if
// Purpose : bundles the pixel-writer handshake and the single BRAM port that
//           the arbiter owns.
// Signals :
//   wr_valid   writer request
//   wr_ready   writer grant (combinational from the arbiter)
//   wr_addr    writer pixel address
//   wr_data    writer pixel value
//   bram_en    BRAM enable (registered)
//   bram_we    BRAM write enable (registered)
//   bram_addr  BRAM address (registered)
//   bram_wdata BRAM write data (registered)
//   bram_rdata BRAM read data, one clock after the enabled read
// Modports:
//   slave  - arbiter side (consumes writer requests, drives the BRAM port)
//   master - environment side (pixel writer plus the BRAM itself)
// ---------------------------------------------------------------------------
interface fb_display_arbiter_if;
  import fb_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_wdata;
  logic [PIX_W-1:0]  bram_rdata;

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    output bram_en,
    output bram_we,
    output bram_addr,
    output bram_wdata,
    input  bram_rdata
  );

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    input  bram_en,
    input  bram_we,
    input  bram_addr,
    input  bram_wdata,
    output bram_rdata
  );

endinterface

// File: rtl/fb_addr_gen.sv
// ---------------------------------------------------------------------------
// fb_addr_gen
// Purpose : combinational mapping from the halved scan position to the
//           frame-buffer address, addr = row * IMG_W + col, where row = y>>1
//           and col = x>>1 are supplied already halved by the caller.
//           The multiply by 320 is built as (row<<8) + (row<<6), so no
//           multiplier is inferred. For row <= 239 and col <= 319 the result
//           is at most 76799 and fits ADDR_W without overflow.
// Ports   :
//   i_col   [8:0]        image column (display x >> 1)
//   i_row   [8:0]        image row    (display y >> 1)
//   o_addr  [ADDR_W-1:0] BRAM address of that image pixel
// ---------------------------------------------------------------------------
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [8:0]        i_col,
  input  logic [8:0]        i_row,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_row_x256;
  logic [ADDR_W-1:0] w_row_x64;
  logic [ADDR_W-1:0] w_col;

  // 320 = 256 + 64; the shifts are hard-wired to that image width.
  assign w_row_x256 = ADDR_W'({i_row, 8'd0});
  assign w_row_x64  = ADDR_W'({i_row, 6'd0});
  assign w_col      = ADDR_W'(i_col);

  assign o_addr = w_row_x256 + w_row_x64 + w_col;

endmodule

// File: rtl/fb_display_arbiter.sv
// ---------------------------------------------------------------------------
// fb_display_arbiter
// Purpose : shares one single-port frame-buffer BRAM between the Sobel pixel
//           writer and the VGA/HDMI scan-out. Display fetches, issued in
//           lock-step with the pixel tick, always own the port; writer
//           accesses use every other cycle. The display stays black until a
//           completed frame has been reported and a frame boundary has passed.
// Ports   :
//   clk_100MHz  system clock
//   reset       asynchronous, active-high reset
//   p_tick      pixel-clock enable (1 cycle in 4)
//   video_on    active display area
//   x, y        current scan column / row (640x480 space)
//   done        Sobel frame-complete pulse
//   bus         writer handshake + BRAM port (slave modport)
//   pix_out     display pixel, fed to R, G and B of the output stage
//   state       FSM state, debug only
// Timing  : decision at T, port registers at T+1, bram_rdata at T+2,
//           pix_out updated at T+3 and held until the next fetch.
// ---------------------------------------------------------------------------
module fb_display_arbiter
  import fb_pkg::*;
(
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 p_tick,
  input  logic                 video_on,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 done,
  fb_display_arbiter_if.slave  bus,
  output logic [PIX_W-1:0]     pix_out,
  output logic [1:0]           state
);

  // Number of clocks from the port registers to the pix_out capture.
  localparam int RD_LAT = 2;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  fb_state_t r_state;
  fb_state_t w_state_next;
  logic      w_frame_start;

  assign w_frame_start = p_tick & (x == 10'd0) & (y == 10'd0);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A done coinciding with a frame start in FILL only arms; scan-out starts
  // at the following frame start so the first shown frame is never torn.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (done) w_state_next = ARMED;
      ARMED:   if (w_frame_start) w_state_next = SHOW;
      SHOW:    w_state_next = SHOW;
      default: w_state_next = FILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // Fetch address and arbitration
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_fetch;
  logic              w_wr_ready;
  logic              w_wr_accept;
  logic              w_wr_in_image;
  logic              w_unused_y0;

  // Halving x and y gives both pixel doubling (odd columns hold the pixel)
  // and line doubling (odd rows repeat the even-row addresses).
  fb_addr_gen u_addr_gen (
    .i_col  (x[9:1]),
    .i_row  (y[9:1]),
    .o_addr (w_fetch_addr)
  );

  // Row parity never matters: odd rows simply re-fetch the even row.
  assign w_unused_y0 = y[0];

  // Fetch only on even columns; the odd column reuses the captured pixel.
  assign w_fetch = (r_state == SHOW) & p_tick & video_on & ~x[0];

  // Grant is combinational so the writer sees the refusal in the same cycle
  // the display claims the port.
  assign w_wr_ready    = ~reset & ~w_fetch;
  assign w_wr_accept   = bus.wr_valid & w_wr_ready;
  assign w_wr_in_image = in_image(bus.wr_addr);

  assign bus.wr_ready = w_wr_ready;

  // -------------------------------------------------------------------------
  // BRAM port registers
  // -------------------------------------------------------------------------
  logic              r_bram_en;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [PIX_W-1:0]  r_bram_wdata;

  logic              w_bram_en_next;
  logic              w_bram_we_next;
  logic [ADDR_W-1:0] w_bram_addr_next;
  logic [PIX_W-1:0]  w_bram_wdata_next;

  // Address/data hold their last value on idle cycles to avoid needless
  // toggling; only en/we are forced low.
  always_comb begin
    w_bram_en_next    = 1'b0;
    w_bram_we_next    = 1'b0;
    w_bram_addr_next  = r_bram_addr;
    w_bram_wdata_next = r_bram_wdata;
    if (w_fetch) begin
      w_bram_en_next   = 1'b1;
      w_bram_addr_next = w_fetch_addr;
    end else if (w_wr_accept && w_wr_in_image) begin
      w_bram_en_next    = 1'b1;
      w_bram_we_next    = 1'b1;
      w_bram_addr_next  = bus.wr_addr;
      w_bram_wdata_next = bus.wr_data;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
    end else begin
      r_bram_en    <= w_bram_en_next;
      r_bram_we    <= w_bram_we_next;
      r_bram_addr  <= w_bram_addr_next;
      r_bram_wdata <= w_bram_wdata_next;
    end
  end

  assign bus.bram_en    = r_bram_en;
  assign bus.bram_we    = r_bram_we;
  assign bus.bram_addr  = r_bram_addr;
  assign bus.bram_wdata = r_bram_wdata;

  // -------------------------------------------------------------------------
  // Read-valid pipeline and pixel capture
  // -------------------------------------------------------------------------
  // Bit 0 marks a read on the port, bit 1 marks its data on bram_rdata.
  // Clearing it on reset drops any read that was in flight.
  logic [RD_LAT-1:0] r_rd_valid;
  logic [PIX_W-1:0]  r_pix;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= {r_rd_valid[RD_LAT-2:0], w_fetch};
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_pix <= '0;
    end else if (r_rd_valid[RD_LAT-1]) begin
      r_pix <= bus.bram_rdata;
    end
  end

  // Before SHOW no fetch is ever issued, so r_pix stays at its reset value
  // and the display is black.
  assign pix_out = r_pix;
  assign state   = r_state;

endmodule

// File: tb/tb_fb_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_display_arbiter
// Randomised scan/writer stimulus; a behavioural model predicts grants, FSM
// state, BRAM accesses and displayed pixels, and a monitor compares them
// against the DUT every clock.
// ---------------------------------------------------------------------------
module tb_fb_display_arbiter;
  import fb_pkg::*;

  logic             clk_100MHz = 1'b0;
  logic             reset      = 1'b1;
  logic             p_tick     = 1'b0;
  logic             video_on   = 1'b0;
  logic [9:0]       x          = '0;
  logic [9:0]       y          = '0;
  logic             done       = 1'b0;
  logic [PIX_W-1:0] pix_out;
  logic [1:0]       state;

  fb_display_arbiter_if bus ();

  fb_display_arbiter dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .done       (done),
    .bus        (bus),
    .pix_out    (pix_out),
    .state      (state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Environment BRAM: registered read, preloaded with addr k = k mod 16.
  logic [PIX_W-1:0] bram_mem [0:131071];
  bit               preloaded;

  always @(posedge clk_100MHz) begin
    if (!preloaded) begin
      for (int k = 0; k < 131072; k++) bram_mem[k] <= 4'(k % 16);
      preloaded <= 1'b1;
    end else if (bus.bram_en) begin
      if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_wdata;
      else             bus.bram_rdata <= bram_mem[bus.bram_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct { int cyc; bit we; int addr; int data; } acc_t;
  typedef struct { int cyc; int val; } pix_t;
  typedef struct { int cyc; bit ready; int st; } st_t;

  acc_t acc_q[$];
  pix_t pix_q[$];
  st_t  st_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit run   = 0;
  int exp_pix = 0;

  // Reference model: image contents and display state (0 fill, 1 armed, 2 show).
  int mmodel [0:76799];
  int mstate = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
  end

  // Monitor
  initial forever begin
    @(negedge clk_100MHz);
    if (run && !reset) begin
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        st_t s;
        s = st_q.pop_front();
        chk("wr_ready", bus.wr_ready, s.ready);
        chk("state", state, s.st);
      end
      while (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
        pix_t p;
        p = pix_q.pop_front();
        exp_pix = p.val;
      end
      chk("pix_out", pix_out, exp_pix);
      if (bus.bram_en) begin
        if (acc_q.size() == 0 || acc_q[0].cyc != cyc) begin
          chk("spurious_bram_en", bus.bram_en, 0);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("bram_we", bus.bram_we, a.we);
          chk("bram_addr", bus.bram_addr, a.addr);
          if (a.we) chk("bram_wdata", bus.bram_wdata, a.data);
        end
      end else begin
        chk("idle_we", bus.bram_we, 0);
        if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
          void'(acc_q.pop_front());
          chk("missing_bram_en", bus.bram_en, 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic step(input bit pt, input bit vo, input int xx, input int yy,
                      input bit dn, input bit wv, input int wa, input int wd);
    bit fetch;
    int a;
    p_tick       = pt;
    video_on     = vo;
    x            = 10'(xx);
    y            = 10'(yy);
    done         = dn;
    bus.wr_valid = wv;
    bus.wr_addr  = 17'(wa);
    bus.wr_data  = 4'(wd);
    fetch = (mstate == 2) && pt && vo && (xx % 2 == 0);
    st_q.push_back('{cyc, !fetch, mstate});
    if (fetch) begin
      a = (yy / 2) * 320 + (xx / 2);
      acc_q.push_back('{cyc + 1, 1'b0, a, 0});
      pix_q.push_back('{cyc + 3, mmodel[a]});
    end else if (wv && wa < 76800) begin
      mmodel[wa] = wd;
      acc_q.push_back('{cyc + 1, 1'b1, wa, wd});
    end
    if (mstate == 0 && dn) mstate = 1;
    else if (mstate == 1 && pt && xx == 0 && yy == 0) mstate = 2;
    @(posedge clk_100MHz);
    #1;
  endtask

  function automatic int rand_waddr();
    if ($urandom_range(7) == 0) return 76800 + int'($urandom_range(999));
    return 1000 + int'($urandom_range(75799));
  endfunction

  // mode 0: random writer traffic; mode 1: writer held valid (with the
  // first out-of-image address on some pixels).
  task automatic scan_row(input int yy, input int x0, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        if (mode == 1)
          step(ph == 0, 1'b1, x0 + i, yy, 1'b0, 1'b1,
               (ph == 1 && i % 4 == 0) ? 76800 : rand_waddr(), int'($urandom_range(15)));
        else
          step(ph == 0, 1'b1, x0 + i, yy, 1'b0, 1'($urandom_range(1)),
               rand_waddr(), int'($urandom_range(15)));
      end
    end
  endtask

  task automatic rand_pixels(input int n);
    int xx, yy;
    bit vo;
    for (int i = 0; i < n; i++) begin
      xx = int'($urandom_range(639));
      yy = int'($urandom_range(479));
      vo = ($urandom_range(3) != 0);
      for (int ph = 0; ph < 4; ph++)
        step(ph == 0, vo, xx, yy, 1'b0, 1'($urandom_range(1)),
             rand_waddr(), int'($urandom_range(15)));
    end
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear at once.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_bram_en", bus.bram_en, 0);
    chk("rst_bram_we", bus.bram_we, 0);
    chk("rst_bram_addr", bus.bram_addr, 0);
    chk("rst_bram_wdata", bus.bram_wdata, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    acc_q.delete();
    pix_q.delete();
    st_q.delete();
    mstate  = 0;
    exp_pix = 0;
    p_tick = 1'b0; video_on = 1'b0; done = 1'b0; bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 76800; k++) mmodel[k] = k % 16;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    @(posedge clk_100MHz);
    #1;
    bus.wr_valid = 1'b1;
    apply_reset();
    run = 1;

    // FILL: writes to 0..9 with 1..10, then restore k mod 16, then random traffic.
    for (int k = 0; k < 10; k++) step(0, 0, 5, 7, 0, 1, k, k + 1);
    for (int k = 0; k < 10; k++) step(0, 0, 5, 7, 0, 1, k, k % 16);
    for (int i = 0; i < 160; i++)
      step(i % 4 == 0, 1'($urandom_range(1)), 1 + int'($urandom_range(600)),
           1 + int'($urandom_range(400)), 0, 1'($urandom_range(1)),
           rand_waddr(), int'($urandom_range(15)));

    // done coincident with frame start: armed only, a frame passes, then SHOW.
    step(1, 1, 0, 0, 1, 0, 0, 0);
    for (int ph = 1; ph < 4; ph++) step(0, 1, 0, 0, 0, 0, 0, 0);
    scan_row(0, 1, 6, 0);
    step(0, 1, 20, 200, 1, 0, 0, 0);
    scan_row(300, 100, 6, 0);
    scan_row(0, 0, 8, 0);

    // SHOW: line doubling on rows 2/3, held writer, blanking, random positions.
    scan_row(2, 0, 16, 0);
    scan_row(3, 0, 16, 0);
    scan_row(10, 0, 16, 1);
    for (int i = 0; i < 40; i++)
      step(i % 4 == 0, 0, 640 + i, 480, 0, 1, rand_waddr(), int'($urandom_range(15)));
    rand_pixels(150);

    // Reset while a read is in flight (port at T+1, data on bram_rdata at T+2).
    step(1, 1, 4, 4, 0, 0, 0, 0);
    step(0, 1, 4, 4, 0, 0, 0, 0);
    apply_reset();
    scan_row(4, 4, 5, 0);

    // done mid-frame at y=100: armed until the next frame start.
    step(0, 1, 50, 100, 1, 0, 0, 0);
    scan_row(100, 51, 10, 0);
    scan_row(0, 0, 6, 0);
    rand_pixels(100);

    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
